// File: rtl/program_loader.sv
// Byte-serial loader for the 256x16 instruction memory: parses SYNC/LEN/data/checksum
// frames and issues one write per assembled instruction while holding the CPU in reset.
module program_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic [7:0]        i_Data,
    input  logic              i_Valid,
    output logic              o_Ready,
    output logic              o_WE,
    output logic [ADDR_W-1:0] o_Addr,
    output logic [15:0]       o_WData,
    output logic              o_CPU_RST,
    output logic              o_Busy,
    output logic              o_Done,
    output logic              o_Error
);

    localparam int unsigned CNT_W = 9;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LEN, HI, LO, WR, CHK, DONE, ERR} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [7:0]        chk, chk_nxt;
    logic [TMR_W-1:0]  timer, timer_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [15:0]       wdata_nxt;
    logic              ready_nxt, we_nxt, cpu_rst_nxt, busy_nxt, done_nxt, error_nxt;
    logic              acc, timed, expired;

    assign acc     = i_Valid && o_Ready;
    assign timed   = (state == LEN) || (state == HI) || (state == LO) || (state == CHK);
    assign expired = (timer == TMR_W'(TIMEOUT));

    // Register stage: every output is loaded from its next-state value.
    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            state     <= IDLE;
            cnt       <= '0;
            chk       <= '0;
            timer     <= '0;
            o_Ready   <= 1'b0;
            o_WE      <= 1'b0;
            o_Addr    <= '0;
            o_WData   <= '0;
            o_CPU_RST <= 1'b0;
            o_Busy    <= 1'b0;
            o_Done    <= 1'b0;
            o_Error   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            chk       <= chk_nxt;
            timer     <= timer_nxt;
            o_Ready   <= ready_nxt;
            o_WE      <= we_nxt;
            o_Addr    <= addr_nxt;
            o_WData   <= wdata_nxt;
            o_CPU_RST <= cpu_rst_nxt;
            o_Busy    <= busy_nxt;
            o_Done    <= done_nxt;
            o_Error   <= error_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        chk_nxt     = chk;
        timer_nxt   = '0;
        addr_nxt    = o_Addr;
        wdata_nxt   = o_WData;
        we_nxt      = 1'b0;
        cpu_rst_nxt = o_CPU_RST;
        busy_nxt    = o_Busy;
        done_nxt    = o_Done;
        error_nxt   = o_Error;

        if (timed && !acc) begin
            timer_nxt = timer + TMR_W'(1);
        end

        // Idle-gap abort wins over any byte arriving on the same cycle.
        if (timed && expired) begin
            state_nxt = ERR;
            error_nxt = 1'b1;
            busy_nxt  = 1'b0;
            timer_nxt = '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    // The CPU runs existing memory once reset has been released.
                    if (state == IDLE) begin
                        cpu_rst_nxt = 1'b1;
                    end
                    if (acc && (i_Data == SYNC_BYTE)) begin
                        state_nxt   = LEN;
                        cpu_rst_nxt = 1'b0;
                        busy_nxt    = 1'b1;
                        done_nxt    = 1'b0;
                        error_nxt   = 1'b0;
                        addr_nxt    = '0;
                        chk_nxt     = '0;
                    end
                end
                LEN: begin
                    if (acc) begin
                        cnt_nxt   = (i_Data == 8'h00) ? CNT_W'(256) : CNT_W'(i_Data);
                        state_nxt = HI;
                    end
                end
                HI: begin
                    if (acc) begin
                        wdata_nxt[15:8] = i_Data;
                        chk_nxt         = chk ^ i_Data;
                        state_nxt       = LO;
                    end
                end
                LO: begin
                    if (acc) begin
                        wdata_nxt[7:0] = i_Data;
                        chk_nxt        = chk ^ i_Data;
                        we_nxt         = 1'b1;
                        state_nxt      = WR;
                    end
                end
                WR: begin
                    cnt_nxt   = cnt - CNT_W'(1);
                    addr_nxt  = o_Addr + ADDR_W'(1);
                    state_nxt = (cnt == CNT_W'(1)) ? CHK : HI;
                end
                CHK: begin
                    if (acc) begin
                        busy_nxt = 1'b0;
                        if (i_Data == chk) begin
                            state_nxt   = DONE;
                            done_nxt    = 1'b1;
                            cpu_rst_nxt = 1'b1;
                        end else begin
                            state_nxt = ERR;
                            error_nxt = 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        ready_nxt = (state_nxt != WR);
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: frames, checksum errors,
// 256-instruction load, timeout, back-to-back bytes and mid-frame reset.
module tb_program_loader;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        data;
    logic              valid;
    logic              ready;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              error;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] mon_addr [0:511];
    logic [15:0]       mon_data [0:511];
    int                wr_cnt = 0;

    always #5 clk = ~clk;

    program_loader #(
        .ADDR_W(ADDR_W),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .i_CLK(clk),
        .i_RST(rst),
        .i_Data(data),
        .i_Valid(valid),
        .o_Ready(ready),
        .o_WE(we),
        .o_Addr(addr),
        .o_WData(wdata),
        .o_CPU_RST(cpu_rst),
        .o_Busy(busy),
        .o_Done(done),
        .o_Error(error)
    );

    // Log every memory write pulse.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (wr_cnt < 512) begin
                mon_addr[wr_cnt] = addr;
                mon_data[wr_cnt] = wdata;
            end
            wr_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Present one byte starting at a falling edge; return at the falling edge after acceptance.
    task automatic send(input logic [7:0] b);
        int n;
        n     = 0;
        data  = b;
        valid = 1'b1;
        while (ready !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8) begin
            checks++;
            errors++;
            $display("FAIL send_ready: byte %h never accepted, ready=%b", b, ready);
        end
        @(negedge clk);
    endtask

    task automatic send_two(input logic [7:0] c);
        send(8'hA5); send(8'h02);
        send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
        send(c);
        valid = 1'b0;
    endtask

    task automatic test_reset();
        int base;
        rst = 1'b0; valid = 1'b0; data = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if ({ready, we, cpu_rst, busy, done, error, addr, wdata} !== 30'd0) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b we=%b cpu=%b busy=%b done=%b err=%b addr=%h wd=%h, want all 0",
                     ready, we, cpu_rst, busy, done, error, addr, wdata);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ready, cpu_rst, we} !== 3'b110) begin
            errors++;
            $display("FAIL reset_release: {ready,cpu_rst,we}=%b, want 110", {ready, cpu_rst, we});
        end
        base = wr_cnt;
        send(8'h00); send(8'h13);
        valid = 1'b0;
        @(negedge clk);
        checks++;
        if ((wr_cnt - base) != 0 || {busy, cpu_rst, done} !== 3'b010) begin
            errors++;
            $display("FAIL idle_garbage: writes=%0d {busy,cpu_rst,done}=%b, want 0 and 010",
                     wr_cnt - base, {busy, cpu_rst, done});
        end
    endtask

    task automatic test_frame();
        int base;
        base = wr_cnt;
        send(8'hA5);
        checks++;
        if ({cpu_rst, busy} !== 2'b01) begin
            errors++;
            $display("FAIL frame_sync: {cpu_rst,busy}=%b, want 01", {cpu_rst, busy});
        end
        send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
        checks++;
        if ({done, cpu_rst} !== 2'b00) begin
            errors++;
            $display("FAIL frame_pre_chk: {done,cpu_rst}=%b, want 00", {done, cpu_rst});
        end
        send(8'h40);
        valid = 1'b0;
        checks++;
        if ({done, error, cpu_rst, busy} !== 4'b1010) begin
            errors++;
            $display("FAIL frame_done: {done,err,cpu_rst,busy}=%b, want 1010", {done, error, cpu_rst, busy});
        end
        checks++;
        if ((wr_cnt - base) != 2 || mon_addr[base] !== 8'd0 || mon_data[base] !== 16'h1234
            || mon_addr[base+1] !== 8'd1 || mon_data[base+1] !== 16'hABCD) begin
            errors++;
            $display("FAIL frame_writes: n=%0d %h@%h %h@%h, want 2 1234@00 abcd@01",
                     wr_cnt - base, mon_data[base], mon_addr[base], mon_data[base+1], mon_addr[base+1]);
        end
    endtask

    task automatic test_bad_checksum();
        int base;
        base = wr_cnt;
        send_two(8'h41);
        checks++;
        if ({done, error, cpu_rst, busy} !== 4'b0100 || (wr_cnt - base) != 2) begin
            errors++;
            $display("FAIL bad_chk: {done,err,cpu_rst,busy}=%b writes=%0d, want 0100 and 2",
                     {done, error, cpu_rst, busy}, wr_cnt - base);
        end
        send_two(8'h40);
        checks++;
        if ({done, error, cpu_rst, busy} !== 4'b1010) begin
            errors++;
            $display("FAIL recover_chk: {done,err,cpu_rst,busy}=%b, want 1010", {done, error, cpu_rst, busy});
        end
    endtask

    task automatic test_full_memory();
        int         base, bad;
        logic [7:0] c, hi, lo;
        base = wr_cnt;
        c    = 8'h00;
        send(8'hA5); send(8'h00);
        for (int i = 0; i < 256; i++) begin
            hi = 8'(i);
            lo = 8'(i * 7 + 3);
            c  = c ^ hi ^ lo;
            send(hi); send(lo);
        end
        send(c);
        valid = 1'b0;
        checks++;
        if ({done, error} !== 2'b10 || (wr_cnt - base) != 256) begin
            errors++;
            $display("FAIL full_done: {done,err}=%b writes=%0d, want 10 and 256", {done, error}, wr_cnt - base);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (mon_addr[base+i] !== 8'(i) || mon_data[base+i] !== {8'(i), 8'(i * 7 + 3)}) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_writes: %0d bad entries, want 0", bad);
        end
        checks++;
        if (mon_addr[base+255] !== 8'hFF) begin
            errors++;
            $display("FAIL full_last_addr: got %h, want ff", mon_addr[base+255]);
        end
    endtask

    task automatic test_timeout();
        int base;
        base = wr_cnt;
        send(8'hA5); send(8'h01); send(8'h12);
        valid = 1'b0;
        repeat (TIMEOUT) @(negedge clk);
        checks++;
        if ({error, busy} !== 2'b01) begin
            errors++;
            $display("FAIL timeout_early: {err,busy}=%b, want 01", {error, busy});
        end
        @(negedge clk);
        checks++;
        if ({error, busy, cpu_rst, done} !== 4'b1000 || (wr_cnt - base) != 0) begin
            errors++;
            $display("FAIL timeout_abort: {err,busy,cpu_rst,done}=%b writes=%0d, want 1000 and 0",
                     {error, busy, cpu_rst, done}, wr_cnt - base);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = wr_cnt;
        send(8'hA5); send(8'h03);
        send(8'hA5); send(8'hA5);
        send(8'h00); send(8'h01);
        send(8'hFF); send(8'hEE);
        send(8'h10);
        valid = 1'b0;
        checks++;
        if ({done, error} !== 2'b10 || (wr_cnt - base) != 3) begin
            errors++;
            $display("FAIL b2b_done: {done,err}=%b writes=%0d, want 10 and 3", {done, error}, wr_cnt - base);
        end
        checks++;
        if (mon_data[base] !== 16'hA5A5 || mon_data[base+1] !== 16'h0001 || mon_data[base+2] !== 16'hFFEE
            || mon_addr[base+2] !== 8'd2) begin
            errors++;
            $display("FAIL b2b_writes: %h %h %h@%h, want a5a5 0001 ffee@02",
                     mon_data[base], mon_data[base+1], mon_data[base+2], mon_addr[base+2]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        base = wr_cnt;
        send(8'hA5); send(8'h03);
        send(8'h11); send(8'h22); send(8'h33);
        valid = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        checks++;
        if ({ready, we, cpu_rst, busy, done, error, addr, wdata} !== 30'd0 || (wr_cnt - base) != 1) begin
            errors++;
            $display("FAIL mid_reset: rdy=%b cpu=%b busy=%b done=%b addr=%h wd=%h writes=%0d, want all 0 and 1",
                     ready, cpu_rst, busy, done, addr, wdata, wr_cnt - base);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ready, cpu_rst, busy} !== 3'b110) begin
            errors++;
            $display("FAIL mid_release: {ready,cpu_rst,busy}=%b, want 110", {ready, cpu_rst, busy});
        end
        send(8'hA5); send(8'h01); send(8'hBE); send(8'hEF); send(8'h51);
        valid = 1'b0;
        checks++;
        if ({done, cpu_rst} !== 2'b11 || (wr_cnt - base) != 2 || mon_data[base+1] !== 16'hBEEF
            || mon_addr[base+1] !== 8'd0) begin
            errors++;
            $display("FAIL mid_reload: {done,cpu_rst}=%b writes=%0d %h@%h, want 11 2 beef@00",
                     {done, cpu_rst}, wr_cnt - base, mon_data[base+1], mon_addr[base+1]);
        end
    endtask

    initial begin
        rst   = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        test_reset();
        test_frame();
        test_bad_checksum();
        test_full_memory();
        test_timeout();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-serial writer for the CPU's 256x16 instruction memory; the write-side counterpart of the PC-driven instruction fetch path.
- Accepts a framed byte stream (sync, length, instruction bytes, checksum) over a valid/ready handshake.
- Assembles 16-bit instructions and issues one write per instruction to the memory write port.
- Holds the CPU in reset (active-low) while a load is in progress and after a failed load.

Parameters:
- ADDR_W, 8, instruction memory address width.
- SYNC_BYTE, 8'hA5, frame start byte.
- TIMEOUT, 65535, max idle cycles between bytes inside a frame before abort.

Ports:
- i_CLK  input  1  system clock, all logic on rising edge.
- i_RST  input  1  reset, synchronous, active-low.
- i_Data  input  8  incoming byte.
- i_Valid  input  1  i_Data valid; byte accepted on a cycle with i_Valid && o_Ready.
- o_Ready  output  1  loader can accept a byte this cycle.
- o_WE  output  1  instruction memory write enable, 1-cycle pulse.
- o_Addr  output  ADDR_W  instruction memory write address.
- o_WData  output  16  instruction memory write data.
- o_CPU_RST  output  1  active-low reset to PC/ALU; 0 holds CPU in reset.
- o_Busy  output  1  frame in progress.
- o_Done  output  1  last frame loaded and checksum matched (sticky).
- o_Error  output  1  last frame failed (checksum or timeout) (sticky).

Behaviour:
- All outputs registered. Reset (i_RST=0 at edge): state IDLE; o_Ready=0, o_WE=0, o_Addr=0, o_WData=0, o_CPU_RST=0, o_Busy=0, o_Done=0, o_Error=0, count/checksum/timer cleared.
- First cycle after reset: o_Ready=1, o_CPU_RST=1 (CPU runs existing memory contents).
- Frame format: SYNC_BYTE, N (0 encodes 256), then N pairs of bytes (high byte first, then low byte), then C. C = XOR of all 2N instruction bytes. Instructions are written to addresses 0..N-1.
- States: IDLE, LEN, HI, LO, WR, CHK, DONE, ERR.
  - IDLE/DONE/ERR: o_Ready=1.
    - Byte == SYNC_BYTE -> LEN. Same edge: o_CPU_RST<=0, o_Busy<=1, o_Done<=0, o_Error<=0, o_Addr<=0, checksum<=0.
    - Any other byte is accepted and dropped.
  - LEN: byte latched as remaining count (0 -> 256, 9-bit counter) -> HI.
  - HI: byte stored as o_WData[15:8], XORed into checksum -> LO.
  - LO: byte stored as o_WData[7:0], XORed into checksum -> WR.
  - WR: one cycle. o_WE=1 with o_Addr/o_WData stable, o_Ready=0, count decremented.
    - Next: HI if count != 0, else CHK.
    - o_Addr increments on the cycle after WR (8-bit wrap; 256th write is at 255, then wraps to 0 unobserved).
  - CHK: byte compared with checksum.
    - Match -> DONE: o_Done=1, o_CPU_RST=1, o_Busy=0.
    - Mismatch -> ERR: o_Error=1, o_CPU_RST stays 0, o_Busy=0.
- Timeout:
  - In LEN/HI/LO/CHK, the timer counts cycles without an accepted byte and clears on each accepted byte.
  - Reaching TIMEOUT -> ERR the following edge.
  - Memory writes already issued are not undone.
- SYNC_BYTE is treated as ordinary data inside a frame (no resync mid-frame).
- o_WE is never asserted outside WR. Exactly N write pulses per complete frame.
- i_RST low mid-frame: immediate return to reset values on that edge. A partial frame is abandoned and o_CPU_RST=0 until the cycle after reset release.
- i_Valid while o_Ready=0 (WR cycle): byte not consumed. The source must hold it until accepted.
- Latency: last LO byte accepted at edge k -> o_WE high during cycle k+1. C accepted at edge m -> o_Done/o_CPU_RST high from m.

Test Plan:
- Reset release -> o_Ready=1, o_CPU_RST=1, o_WE=0 next cycle. Stream 0x00,0x13 in IDLE -> ignored, no o_WE.
- Frame A5,02,12,34,AB,CD,checksum 0x12^0x34^0xAB^0xCD=0x40 -> writes 0x1234@0, 0xABCD@1. o_CPU_RST=0 from sync until checksum, then o_Done=1, o_CPU_RST=1.
- Same frame with checksum 0x41 -> both writes occur, o_Error=1, o_Done=0, o_CPU_RST stays 0. A following correct frame clears o_Error and sets o_Done.
- N=0x00 with 512 bytes -> 256 writes, addresses 0..255 in order, o_Done=1 with correct checksum.
- TIMEOUT=16: A5,01,12 then idle 16 cycles -> ERR, o_Error=1, no o_WE. i_Valid held high across every WR cycle -> no byte lost or duplicated.
- Assert i_RST during LO of a 3-instruction frame -> all outputs at reset values. After release, o_CPU_RST=1 and the state machine accepts a new frame.
